// File: rtl/ravenoc_axi_port_steer_if.sv
// ravenoc_axi_port_steer_if: upstream AXI4 channel plus per-port downstream NI channels
interface ravenoc_axi_port_steer_if #(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [ID_W-1:0]   up_awid;
  logic [ADDR_W-1:0] up_awaddr;
  logic [7:0]        up_awlen;
  logic              up_awvalid;
  logic              up_awready;
  logic [DATA_W-1:0] up_wdata;
  logic              up_wlast;
  logic              up_wvalid;
  logic              up_wready;
  logic [ID_W-1:0]   up_bid;
  logic [1:0]        up_bresp;
  logic              up_bvalid;
  logic              up_bready;
  logic [ID_W-1:0]   up_arid;
  logic [ADDR_W-1:0] up_araddr;
  logic [7:0]        up_arlen;
  logic              up_arvalid;
  logic              up_arready;
  logic [ID_W-1:0]   up_rid;
  logic [DATA_W-1:0] up_rdata;
  logic [1:0]        up_rresp;
  logic              up_rlast;
  logic              up_rvalid;
  logic              up_rready;
  logic [NUM_PORTS-1:0][ID_W-1:0]   dn_awid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] dn_awaddr;
  logic [NUM_PORTS-1:0][7:0]        dn_awlen;
  logic [NUM_PORTS-1:0]             dn_awvalid;
  logic [NUM_PORTS-1:0]             dn_awready;
  logic [NUM_PORTS-1:0][DATA_W-1:0] dn_wdata;
  logic [NUM_PORTS-1:0]             dn_wlast;
  logic [NUM_PORTS-1:0]             dn_wvalid;
  logic [NUM_PORTS-1:0]             dn_wready;
  logic [NUM_PORTS-1:0][ID_W-1:0]   dn_bid;
  logic [NUM_PORTS-1:0][1:0]        dn_bresp;
  logic [NUM_PORTS-1:0]             dn_bvalid;
  logic [NUM_PORTS-1:0]             dn_bready;
  logic [NUM_PORTS-1:0][ID_W-1:0]   dn_arid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] dn_araddr;
  logic [NUM_PORTS-1:0][7:0]        dn_arlen;
  logic [NUM_PORTS-1:0]             dn_arvalid;
  logic [NUM_PORTS-1:0]             dn_arready;
  logic [NUM_PORTS-1:0][ID_W-1:0]   dn_rid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] dn_rdata;
  logic [NUM_PORTS-1:0][1:0]        dn_rresp;
  logic [NUM_PORTS-1:0]             dn_rlast;
  logic [NUM_PORTS-1:0]             dn_rvalid;
  logic [NUM_PORTS-1:0]             dn_rready;
  modport slave (
    input  up_awid, up_awaddr, up_awlen, up_awvalid, up_wdata, up_wlast, up_wvalid, up_bready,
           up_arid, up_araddr, up_arlen, up_arvalid, up_rready,
    output up_awready, up_wready, up_bid, up_bresp, up_bvalid, up_arready,
           up_rid, up_rdata, up_rresp, up_rlast, up_rvalid,
    output dn_awid, dn_awaddr, dn_awlen, dn_awvalid, dn_wdata, dn_wlast, dn_wvalid, dn_bready,
           dn_arid, dn_araddr, dn_arlen, dn_arvalid, dn_rready,
    input  dn_awready, dn_wready, dn_bid, dn_bresp, dn_bvalid, dn_arready,
           dn_rid, dn_rdata, dn_rresp, dn_rlast, dn_rvalid
  );
  modport master (
    output up_awid, up_awaddr, up_awlen, up_awvalid, up_wdata, up_wlast, up_wvalid, up_bready,
           up_arid, up_araddr, up_arlen, up_arvalid, up_rready,
    input  up_awready, up_wready, up_bid, up_bresp, up_bvalid, up_arready,
           up_rid, up_rdata, up_rresp, up_rlast, up_rvalid,
    input  dn_awid, dn_awaddr, dn_awlen, dn_awvalid, dn_wdata, dn_wlast, dn_wvalid, dn_bready,
           dn_arid, dn_araddr, dn_arlen, dn_arvalid, dn_rready,
    output dn_awready, dn_wready, dn_bid, dn_bresp, dn_bvalid, dn_arready,
           dn_rid, dn_rdata, dn_rresp, dn_rlast, dn_rvalid
  );
endinterface

// File: rtl/ravenoc_axi_port_steer.sv
// ravenoc_axi_port_steer: steers one AXI4 master to a run-time selected NI port, switching only when drained
module ravenoc_axi_port_steer #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_OUTST = 4,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk_axi,
  input  logic          arst_axi,
  input  logic          sel_valid,
  input  logic [PW-1:0] sel_port,
  output logic          sel_ready,
  output logic          sel_err,
  output logic [PW-1:0] cur_port,
  output logic          port_active,
  output logic          busy,
  ravenoc_axi_port_steer_if.slave axi
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_nx;
  logic [PW-1:0] nxt_port, cur_nx, nxt_nx;
  logic [CW-1:0] wr_cnt, rd_cnt, w_pend;
  logic in_range, drained, aw_ok, ar_ok, w_ok, aw_hs, wl_hs, b_hs, ar_hs, rl_hs;
  assign in_range    = int'(sel_port) < NUM_PORTS;
  assign drained     = wr_cnt == '0 && rd_cnt == '0 && w_pend == '0;
  assign port_active = state != IDLE;
  assign busy        = wr_cnt != '0 || rd_cnt != '0;
  assign aw_ok = state == ACTIVE && wr_cnt < CW'(MAX_OUTST);
  assign ar_ok = state == ACTIVE && rd_cnt < CW'(MAX_OUTST);
  assign aw_hs = aw_ok && axi.up_awvalid && axi.dn_awready[cur_port];
  assign w_ok  = port_active && (w_pend != '0 || aw_hs);
  assign wl_hs = w_ok && axi.up_wvalid && axi.dn_wready[cur_port] && axi.up_wlast;
  assign b_hs  = port_active && axi.dn_bvalid[cur_port] && axi.up_bready;
  assign ar_hs = ar_ok && axi.up_arvalid && axi.dn_arready[cur_port];
  assign rl_hs = port_active && axi.dn_rvalid[cur_port] && axi.up_rready && axi.dn_rlast[cur_port];
  // state, selected ports and outstanding-transaction counters
  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      state    <= IDLE;
      cur_port <= '0;
      nxt_port <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      w_pend   <= '0;
    end else begin
      state    <= state_nx;
      cur_port <= cur_nx;
      nxt_port <= nxt_nx;
      wr_cnt   <= wr_cnt + CW'(aw_hs) - CW'(b_hs);
      rd_cnt   <= rd_cnt + CW'(ar_hs) - CW'(rl_hs);
      w_pend   <= w_pend + CW'(aw_hs) - CW'(wl_hs);
    end
  end
  // selection handshake and port-switch sequencing
  always_comb begin
    state_nx  = state;
    cur_nx    = cur_port;
    nxt_nx    = nxt_port;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    case (state)
      IDLE: if (sel_valid) begin
        sel_ready = 1'b1;
        sel_err   = !in_range;
        if (in_range) begin
          cur_nx   = sel_port;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: if (sel_valid) begin
        sel_ready = !in_range || sel_port == cur_port;
        sel_err   = !in_range;
        if (in_range && sel_port != cur_port) begin
          nxt_nx   = sel_port;
          state_nx = DRAIN;
        end
      end
      DRAIN: if (drained) begin
        sel_ready = 1'b1;
        cur_nx    = nxt_port;
        state_nx  = ACTIVE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // route the selected port only; everything else sees zeros, upstream readies are gated
  always_comb begin
    axi.dn_awid    = '0;
    axi.dn_awaddr  = '0;
    axi.dn_awlen   = '0;
    axi.dn_awvalid = '0;
    axi.dn_wdata   = '0;
    axi.dn_wlast   = '0;
    axi.dn_wvalid  = '0;
    axi.dn_bready  = '0;
    axi.dn_arid    = '0;
    axi.dn_araddr  = '0;
    axi.dn_arlen   = '0;
    axi.dn_arvalid = '0;
    axi.dn_rready  = '0;
    axi.up_awready = 1'b0;
    axi.up_wready  = 1'b0;
    axi.up_bid     = '0;
    axi.up_bresp   = '0;
    axi.up_bvalid  = 1'b0;
    axi.up_arready = 1'b0;
    axi.up_rid     = '0;
    axi.up_rdata   = '0;
    axi.up_rresp   = '0;
    axi.up_rlast   = 1'b0;
    axi.up_rvalid  = 1'b0;
    if (port_active) begin
      axi.dn_awid[cur_port]    = axi.up_awid;
      axi.dn_awaddr[cur_port]  = axi.up_awaddr;
      axi.dn_awlen[cur_port]   = axi.up_awlen;
      axi.dn_awvalid[cur_port] = axi.up_awvalid && aw_ok;
      axi.dn_wdata[cur_port]   = axi.up_wdata;
      axi.dn_wlast[cur_port]   = axi.up_wlast;
      axi.dn_wvalid[cur_port]  = axi.up_wvalid && w_ok;
      axi.dn_bready[cur_port]  = axi.up_bready;
      axi.dn_arid[cur_port]    = axi.up_arid;
      axi.dn_araddr[cur_port]  = axi.up_araddr;
      axi.dn_arlen[cur_port]   = axi.up_arlen;
      axi.dn_arvalid[cur_port] = axi.up_arvalid && ar_ok;
      axi.dn_rready[cur_port]  = axi.up_rready;
      axi.up_awready = axi.dn_awready[cur_port] && aw_ok;
      axi.up_wready  = axi.dn_wready[cur_port] && w_ok;
      axi.up_bid     = axi.dn_bid[cur_port];
      axi.up_bresp   = axi.dn_bresp[cur_port];
      axi.up_bvalid  = axi.dn_bvalid[cur_port];
      axi.up_arready = axi.dn_arready[cur_port] && ar_ok;
      axi.up_rid     = axi.dn_rid[cur_port];
      axi.up_rdata   = axi.dn_rdata[cur_port];
      axi.up_rresp   = axi.dn_rresp[cur_port];
      axi.up_rlast   = axi.dn_rlast[cur_port];
      axi.up_rvalid  = axi.dn_rvalid[cur_port];
    end
  end
  a_port_range: assert property (@(posedge clk_axi) disable iff (!arst_axi) int'(cur_port) < NUM_PORTS);
  a_wr_under:   assert property (@(posedge clk_axi) disable iff (!arst_axi) b_hs |-> wr_cnt != '0);
  a_rd_under:   assert property (@(posedge clk_axi) disable iff (!arst_axi) rl_hs |-> rd_cnt != '0);
  a_w_under:    assert property (@(posedge clk_axi) disable iff (!arst_axi) wl_hs |-> (w_pend != '0 || aw_hs));
  a_dn_isolate: assert property (@(posedge clk_axi) disable iff (!arst_axi)
    ((axi.dn_awvalid | axi.dn_wvalid | axi.dn_arvalid) & ~(NUM_PORTS'(1) << cur_port)) == '0);
endmodule
